// File: rtl/sdr_init_refresh_seq_if.sv
// SDRAM init/refresh sequencer bus: command pins, mode config, refresh handshake.
// master = sequencer (drives command pins and flags), slave = controller side.
interface sdr_init_refresh_seq_if;
  logic [2:0]  cfg_sdr_cas;
  logic [2:0]  cfg_burst_len;
  logic        ref_gnt;
  logic        sdr_cs_n;
  logic        sdr_ras_n;
  logic        sdr_cas_n;
  logic        sdr_we_n;
  logic [12:0] sdr_addr;
  logic [1:0]  sdr_ba;
  logic        sdr_init_done;
  logic        ref_req;
  logic        ref_busy;
  logic        ref_done;
  logic        ref_overrun;

  modport master (
    input  cfg_sdr_cas, cfg_burst_len, ref_gnt,
    output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    output sdr_addr, sdr_ba, sdr_init_done,
    output ref_req, ref_busy, ref_done, ref_overrun
  );

  modport slave (
    output cfg_sdr_cas, cfg_burst_len, ref_gnt,
    input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    input  sdr_addr, sdr_ba, sdr_init_done,
    input  ref_req, ref_busy, ref_done, ref_overrun
  );
endinterface

// File: rtl/sdr_init_refresh_seq.sv
// SDRAM power-up init (NOP, PRE ALL, N x AREF, LMR) then periodic AREF scheduling.
// Ports: sys_clk, reset_n (async low), bus (master: cmd pins, cfg in, refresh handshake).
module sdr_init_refresh_seq #(
  parameter int PWRUP_CYC = 10000,
  parameter int TRP       = 8,
  parameter int TRFC      = 10,
  parameter int INIT_REF  = 16,
  parameter int TMRD      = 18,
  parameter int REF_INT   = 1560,
  parameter int MAX_PEND  = 8
) (
  input logic sys_clk,
  input logic reset_n,
  sdr_init_refresh_seq_if.master bus
);

  localparam int M1 = (PWRUP_CYC > TRP) ? PWRUP_CYC : TRP;
  localparam int M2 = (TRFC > TMRD) ? TRFC : TMRD;
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MX + 1);
  localparam int RW = $clog2(INIT_REF + 1);
  localparam int TW = $clog2(REF_INT + 1);
  localparam int PW = $clog2(MAX_PEND + 1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] C_INH  = 4'b1111;
  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_LMR  = 4'b0000;

  typedef enum logic [3:0] {
    S_PWRUP, S_PRE, S_WAIT_RP, S_AREF, S_WAIT_RFC,
    S_LMR, S_WAIT_MRD, S_IDLE, S_RREF, S_RWAIT
  } state_t;

  state_t          state;
  logic [3:0]      cmd;
  logic [12:0]     addr;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   nref;
  logic [TW-1:0]   tmr;
  logic [PW-1:0]   pend;
  logic            init_done;
  logic            busy;
  logic            done;
  logic            ovr;
  logic            expire;
  logic            dec;
  logic            pend_max;

  assign expire   = init_done && (tmr == TW'(REF_INT - 1));
  assign dec      = (state == S_RWAIT) && (cnt == CW'(TRFC - 1));
  assign pend_max = (pend == PW'(MAX_PEND));

  assign bus.sdr_cs_n      = cmd[3];
  assign bus.sdr_ras_n     = cmd[2];
  assign bus.sdr_cas_n     = cmd[1];
  assign bus.sdr_we_n      = cmd[0];
  assign bus.sdr_addr      = addr;
  assign bus.sdr_ba        = 2'b00;
  assign bus.sdr_init_done = init_done;
  assign bus.ref_req       = (state == S_IDLE) && (pend != '0);
  assign bus.ref_busy      = busy;
  assign bus.ref_done      = done;
  assign bus.ref_overrun   = ovr;

  // cnt holds the number of cycles since the last issued command,
  // so a wait of T cycles ends when cnt reads T.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_PWRUP;
      cmd       <= C_INH;
      addr      <= '0;
      cnt       <= '0;
      nref      <= '0;
      tmr       <= '0;
      pend      <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      cmd  <= C_NOP;
      addr <= '0;
      done <= 1'b0;

      if (init_done)
        tmr <= expire ? '0 : tmr + TW'(1);

      if (expire && pend_max)
        ovr <= 1'b1;

      // simultaneous expiry and completion cancel out
      if (expire && !dec) begin
        if (!pend_max)
          pend <= pend + PW'(1);
      end else if (dec && !expire) begin
        pend <= pend - PW'(1);
      end

      unique case (state)
        S_PWRUP: begin
          if (cnt == CW'(PWRUP_CYC)) begin
            state <= S_PRE;
            cmd   <= C_PRE;
            addr  <= 13'h0400;
            cnt   <= CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PRE: begin
          state <= S_WAIT_RP;
          cnt   <= cnt + CW'(1);
        end
        S_WAIT_RP: begin
          if (cnt == CW'(TRP)) begin
            state <= S_AREF;
            cmd   <= C_AREF;
            cnt   <= CW'(1);
            nref  <= nref + RW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_AREF: begin
          state <= S_WAIT_RFC;
          cnt   <= cnt + CW'(1);
        end
        S_WAIT_RFC: begin
          if (cnt == CW'(TRFC)) begin
            cnt <= CW'(1);
            if (nref == RW'(INIT_REF)) begin
              state <= S_LMR;
              cmd   <= C_LMR;
              addr  <= {6'b000000,
                        bus.cfg_sdr_cas, 1'b0,
                        bus.cfg_burst_len};
            end else begin
              state <= S_AREF;
              cmd   <= C_AREF;
              nref  <= nref + RW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LMR: begin
          state <= S_WAIT_MRD;
          cnt   <= cnt + CW'(1);
        end
        S_WAIT_MRD: begin
          if (cnt == CW'(TMRD)) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if ((pend != '0) && bus.ref_gnt) begin
            state <= S_RREF;
            cmd   <= C_AREF;
            busy  <= 1'b1;
            cnt   <= CW'(1);
          end
        end
        S_RREF: begin
          state <= S_RWAIT;
          cnt   <= cnt + CW'(1);
        end
        S_RWAIT: begin
          if (cnt == CW'(TRFC)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt  <= cnt + CW'(1);
            done <= dec;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule
